// File: rtl/sram_arbiter_pkg.sv
// Shared types and default sizing for the two-port SRAM arbiter.
// The state and requester-ID enums are kept here so the bench can use them too.
package sram_arb_pkg;

   localparam int ADDR_W_DEF    = 20;
   localparam int DATA_W_DEF    = 16;
   localparam int RD_CYCLES_DEF = 2;
   localparam int WR_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DMA = 1'b1
   } req_id_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester handshakes plus the SRAM pin bundle for sram_arbiter.
// The slave modport is the arbiter's view; master is the requester/SRAM side.
interface sram_arbiter_if
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_ack;
   logic [DATA_W-1:0] dma_rdata;

   logic              Mem_CE;
   logic              Mem_UB;
   logic              Mem_LB;
   logic              Mem_OE;
   logic              Mem_WE;
   logic [ADDR_W-1:0] Mem_ADDR;
   logic [DATA_W-1:0] Data_to_SRAM;
   logic [DATA_W-1:0] Data_from_SRAM;
   logic              busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_ack, dma_rdata,
      output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_ADDR, Data_to_SRAM,
      input  Data_from_SRAM,
      output busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_ack, dma_rdata,
      input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_ADDR, Data_to_SRAM,
      output Data_from_SRAM,
      input  busy
   );
endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_arb2
   import sram_arb_pkg::*;
(
   input  logic    req_cpu_i,
   input  logic    req_dma_i,
   input  req_id_e last_grant_i,
   output logic    gnt_valid_o,
   output req_id_e gnt_id_o
);
   always_comb begin
      gnt_valid_o = req_cpu_i | req_dma_i;
      gnt_id_o    = REQ_CPU;
      if (req_cpu_i && req_dma_i)
         gnt_id_o = (last_grant_i == REQ_CPU) ? REQ_DMA : REQ_CPU;
      else if (req_dma_i)
         gnt_id_o = REQ_DMA;
   end
endmodule

// File: rtl/sram_arbiter.sv
// CPU/DMA arbiter for an asynchronous SRAM with fixed-length read/write strobes.
// state | meaning
// IDLE  | waiting for a request, arbitration and latching happen here
// READ  | OE low for RD_CYCLES, data captured on the last edge
// WRITE | WE low for WR_CYCLES, address/data held stable
// DONE  | one-cycle ack to the granted requester, strobes high
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int RD_CYCLES = RD_CYCLES_DEF,
   parameter int WR_CYCLES = WR_CYCLES_DEF
) (
   input  logic          Clk,
   input  logic          Reset,
   sram_arbiter_if.slave bus
);
   localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

   state_e            state_q;
   req_id_e           gnt_q;
   req_id_e           last_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              oe_q;
   logic              we_q;
   logic              cpu_ack_q;
   logic              dma_ack_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dma_rdata_q;

   logic              gnt_valid;
   req_id_e           gnt_id;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arb2 u_rr_arb2 (
      .req_cpu_i    (bus.cpu_req),
      .req_dma_i    (bus.dma_req),
      .last_grant_i (last_q),
      .gnt_valid_o  (gnt_valid),
      .gnt_id_o     (gnt_id)
   );

   always_comb begin
      sel_we    = bus.cpu_we;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
      if (gnt_id == REQ_DMA) begin
         sel_we    = bus.dma_we;
         sel_addr  = bus.dma_addr;
         sel_wdata = bus.dma_wdata;
      end
   end

   // Strobes and acks are registered and set one edge ahead of the state they belong to.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         gnt_q       <= REQ_CPU;
         last_q      <= REQ_DMA;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         oe_q        <= 1'b1;
         we_q        <= 1'b1;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         cpu_ack_q <= 1'b0;
         dma_ack_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (gnt_valid) begin
                  gnt_q   <= gnt_id;
                  last_q  <= gnt_id;
                  cnt_q   <= '0;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  if (sel_we) begin
                     we_q    <= 1'b0;
                     state_q <= S_WRITE;
                  end else begin
                     oe_q    <= 1'b0;
                     state_q <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (cnt_q == RD_LAST) begin
                  oe_q    <= 1'b1;
                  state_q <= S_DONE;
                  if (gnt_q == REQ_CPU) begin
                     cpu_rdata_q <= bus.Data_from_SRAM;
                     cpu_ack_q   <= 1'b1;
                  end else begin
                     dma_rdata_q <= bus.Data_from_SRAM;
                     dma_ack_q   <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_WRITE: begin
               if (cnt_q == WR_LAST) begin
                  we_q    <= 1'b1;
                  state_q <= S_DONE;
                  if (gnt_q == REQ_CPU) cpu_ack_q <= 1'b1;
                  else                  dma_ack_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.Mem_CE       = 1'b0;
   assign bus.Mem_UB       = 1'b0;
   assign bus.Mem_LB       = 1'b0;
   assign bus.Mem_OE       = oe_q;
   assign bus.Mem_WE       = we_q;
   assign bus.Mem_ADDR     = addr_q;
   assign bus.Data_to_SRAM = wdata_q;
   assign bus.cpu_ack      = cpu_ack_q;
   assign bus.dma_ack      = dma_ack_q;
   assign bus.cpu_rdata    = cpu_rdata_q;
   assign bus.dma_rdata    = dma_rdata_q;
   assign bus.busy         = (state_q != S_IDLE);
endmodule
